// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcode constants and shifter state encoding
package alu_pkg;

  localparam logic [4:0] ALU_OP_SLL = 5'b00100;
  localparam logic [4:0] ALU_OP_SRA = 5'b00101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_stage.sv
// rtl/shift_stage.sv - one logarithmic shift stage (16/8/4/2/1 chosen by index)
module shift_stage (
  input  logic [31:0] data_in,
  input  logic [2:0]  stage_idx,
  input  logic        arith,
  input  logic        enable,
  output logic [31:0] data_out
);

  logic [4:0] amt;

  // Map the stage index to its power-of-two shift distance.
  always_comb begin
    case (stage_idx)
      3'd0:    amt = 5'd1;
      3'd1:    amt = 5'd2;
      3'd2:    amt = 5'd4;
      3'd3:    amt = 5'd8;
      3'd4:    amt = 5'd16;
      default: amt = 5'd0;
    endcase
  end

  // Arithmetic mode shifts right replicating bit 31; otherwise logical left.
  always_comb begin
    data_out = data_in;
    if (enable) begin
      if (arith) begin
        data_out = $signed(data_in) >>> amt;
      end else begin
        data_out = data_in << amt;
      end
    end
  end

endmodule

// File: rtl/iterative_shifter.sv
// rtl/iterative_shifter.sv - five-cycle iterative SLL/SRA unit with valid/ready handshakes
module iterative_shifter
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       ctrl_ALUopcode,
  input  logic [4:0]       ctrl_shiftamt,
  input  logic [WIDTH-1:0] data_operandA,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_result,
  output logic             busy
);

  localparam logic [2:0] IDX_INIT = 3'(STAGES - 1);

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] stage_out;
  logic [4:0]       shamt;
  logic [4:0]       op;
  logic [2:0]       idx;
  logic [7:0]       shamt_ext;
  logic             is_shift_op;
  logic             stage_en;

  // Pad the latched amount so any idx value selects a defined bit.
  assign shamt_ext   = {3'b000, shamt};
  assign is_shift_op = (op == ALU_OP_SLL) || (op == ALU_OP_SRA);
  assign stage_en    = is_shift_op && shamt_ext[idx];

  shift_stage u_stage (
    .data_in   (acc),
    .stage_idx (idx),
    .arith     (op == ALU_OP_SRA),
    .enable    (stage_en),
    .data_out  (stage_out)
  );

  // State register; reset drops any in-flight request.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state: accept in IDLE, run five stages, wait for the consumer in DONE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (in_valid) next_state = SHIFT;
      SHIFT:   if (idx == 3'd0) next_state = DONE;
      DONE:    if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Handshake outputs are pure functions of the state.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  // Datapath: capture request on accept, apply one stage per SHIFT cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      acc   <= '0;
      shamt <= '0;
      op    <= '0;
      idx   <= IDX_INIT;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            acc   <= data_operandA;
            shamt <= ctrl_shiftamt;
            op    <= ctrl_ALUopcode;
            idx   <= IDX_INIT;
          end
        end
        SHIFT: begin
          acc <= stage_out;
          idx <= (idx == 3'd0) ? IDX_INIT : idx - 3'd1;
        end
        default: begin
        end
      endcase
    end
  end

  assign data_result = acc;

endmodule

// File: tb/tb_iterative_shifter.sv
// tb/tb_iterative_shifter.sv - randomized self-checking bench with behavioural shift model
module tb_iterative_shifter;

  localparam logic [4:0] OP_SLL = 5'b00100;
  localparam logic [4:0] OP_SRA = 5'b00101;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  ctrl_ALUopcode;
  logic [4:0]  ctrl_shiftamt;
  logic [31:0] data_operandA;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] data_result;
  logic        busy;

  int checks = 0;
  int errors = 0;
  bit chk_on = 0;

  iterative_shifter dut (
    .clock          (clock),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .ctrl_ALUopcode (ctrl_ALUopcode),
    .ctrl_shiftamt  (ctrl_shiftamt),
    .data_operandA  (data_operandA),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .data_result    (data_result),
    .busy           (busy)
  );

  initial clock = 0;
  always #5 clock = ~clock;

  function automatic logic [31:0] ref_shift(input logic [4:0] op, input logic [4:0] amt,
                                            input logic [31:0] a);
    logic signed [31:0] s;
    s = a;
    if (op == OP_SLL) return a << amt;
    if (op == OP_SRA) return s >>> amt;
    return a;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: idle / working (counting cycles) / holding a result.
  int          m_phase = 0;
  int          m_cnt = 0;
  logic [31:0] m_exp = 0;

  always @(posedge clock) begin
    if (reset) begin
      m_phase = 0;
    end else if (m_phase == 0) begin
      if (in_valid) begin
        m_phase = 1;
        m_cnt   = 0;
        m_exp   = ref_shift(ctrl_ALUopcode, ctrl_shiftamt, data_operandA);
      end
    end else if (m_phase == 1) begin
      m_cnt++;
      if (m_cnt == 5) m_phase = 2;
    end else begin
      if (out_ready) m_phase = 0;
    end
  end

  // Per-cycle comparison of handshake outputs and result against the model.
  always @(negedge clock) begin
    if (chk_on) begin
      chk("in_ready", {31'b0, in_ready}, {31'b0, m_phase == 0});
      chk("out_valid", {31'b0, out_valid}, {31'b0, m_phase == 2});
      chk("busy", {31'b0, busy}, {31'b0, m_phase != 0});
      if (m_phase == 2) chk("data_result", data_result, m_exp);
    end
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic scramble_inputs();
    in_valid       = 1'($urandom);
    ctrl_ALUopcode = 5'($urandom);
    ctrl_shiftamt  = 5'($urandom);
    data_operandA  = $urandom;
  endtask

  // One request: accept, wait for result with a cycle bound, hold, then drain.
  task automatic run_req(input logic [4:0] op, input logic [4:0] amt, input logic [31:0] a,
                         input int hold, input bit scramble, input bit lit_on,
                         input logic [31:0] lit);
    int n;
    in_valid       = 1;
    ctrl_ALUopcode = op;
    ctrl_shiftamt  = amt;
    data_operandA  = a;
    out_ready      = 0;
    step();
    in_valid = 0;
    n = 0;
    while (!out_valid && n < 20) begin
      if (scramble) scramble_inputs();
      step();
      n++;
    end
    in_valid = 0;
    chk("latency", n, 5);
    if (lit_on) chk("literal_result", data_result, lit);
    for (int i = 0; i < hold; i++) begin
      if (scramble) scramble_inputs();
      step();
    end
    in_valid  = 0;
    out_ready = 1;
    step();
    out_ready = 0;
  endtask

  initial begin
    logic [4:0]  op;
    logic [31:0] held;
    reset          = 1;
    in_valid       = 0;
    out_ready      = 0;
    ctrl_ALUopcode = 0;
    ctrl_shiftamt  = 0;
    data_operandA  = 0;
    step();
    step();
    chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
    chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_result", data_result, 32'd0);
    reset = 0;
    chk_on = 1;

    // Pin the reference model to hand-computed values.
    chk("model_sra16", ref_shift(OP_SRA, 5'd16, 32'h80000000), 32'hFFFF8000);
    chk("model_sll31", ref_shift(OP_SLL, 5'd31, 32'h00000001), 32'h80000000);
    chk("model_pass", ref_shift(5'd0, 5'd7, 32'h12345678), 32'h12345678);

    // Directed cases with literal expectations.
    run_req(OP_SRA, 5'd16, 32'h80000000, 0, 0, 1, 32'hFFFF8000);
    run_req(OP_SRA, 5'd16, 32'h7FFF0000, 0, 0, 1, 32'h00007FFF);
    run_req(OP_SLL, 5'd31, 32'h00000001, 0, 0, 1, 32'h80000000);
    run_req(OP_SLL, 5'd0,  32'hDEADBEEF, 0, 0, 1, 32'hDEADBEEF);
    run_req(OP_SRA, 5'd31, 32'hF0000000, 0, 0, 1, 32'hFFFFFFFF);
    run_req(5'd0,   5'd7,  32'h12345678, 0, 0, 1, 32'h12345678);
    run_req(OP_SLL, 5'd21, 32'hA5A5A5A5, 1, 1, 1, 32'hB4A00000);

    // Backpressure with a second request pending through the handshake.
    in_valid       = 1;
    ctrl_ALUopcode = OP_SRA;
    ctrl_shiftamt  = 5'd4;
    data_operandA  = 32'h80000010;
    step();
    ctrl_ALUopcode = OP_SLL;
    ctrl_shiftamt  = 5'd8;
    data_operandA  = 32'h00C0FFEE;
    for (int i = 0; i < 5; i++) step();
    chk("bp_first", data_result, 32'hF8000001);
    held = data_result;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_hold_data", data_result, held);
      chk("bp_no_accept", {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1;
    step();
    out_ready = 0;
    chk("bp_ready_after", {31'b0, in_ready}, 32'd1);
    step();
    in_valid = 0;
    chk("bp_second_taken", {31'b0, busy}, 32'd1);
    for (int i = 0; i < 5; i++) step();
    chk("bp_second", data_result, 32'hC0FFEE00);
    out_ready = 1;
    step();
    out_ready = 0;

    // Reset during SHIFT: the request vanishes.
    in_valid       = 1;
    ctrl_ALUopcode = OP_SRA;
    ctrl_shiftamt  = 5'd5;
    data_operandA  = 32'h87654321;
    step();
    in_valid = 0;
    step();
    step();
    reset = 1;
    step();
    chk("rst_mid_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_mid_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_mid_busy", {31'b0, busy}, 32'd0);
    reset = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("rst_no_stale", {31'b0, out_valid}, 32'd0);
    end

    // Randomized traffic checked by the model every cycle.
    for (int t = 0; t < 200; t++) begin
      case ($urandom_range(0, 2))
        0:       op = OP_SLL;
        1:       op = OP_SRA;
        default: op = 5'($urandom);
      endcase
      run_req(op, 5'($urandom), $urandom, int'($urandom_range(0, 3)),
              1'($urandom), 0, 32'd0);
      if ($urandom_range(0, 3) == 0) step();
    end

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/iterative_shifter.md
Name: iterative_shifter

Overview:
Multi-cycle shift execution unit for the processor's ALU shift path. It accepts one operand, a shift opcode and a 5-bit shift amount through a valid/ready handshake. It applies one logarithmic stage per clock: 16, 8, 4, 2, then 1. It then presents the 32-bit result on a valid/ready output. It replaces the single-cycle barrel chain when timing on the shift path is too tight.

Parameters:
WIDTH, 32, datapath width; only 32 is supported.
STAGES, 5, number of log stages; fixed at log2(WIDTH).

Ports:
clock  input  1  system clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  request present on the input side
in_ready  output  1  unit can accept a request
ctrl_ALUopcode  input  5  00100 = SLL, 00101 = SRA; any other value = pass-through
ctrl_shiftamt  input  5  shift amount, 0 to 31
data_operandA  input  32  operand to shift
out_valid  output  1  result available
out_ready  input  1  consumer accepts the result
data_result  output  32  shifted result
busy  output  1  high in SHIFT or DONE

Behaviour:
- Reset:
  - Applied at the next rising edge while reset = 1.
  - State goes to IDLE, in_ready = 1, out_valid = 0, busy = 0.
  - data_result = 0, acc = 0, stage index = 4.
  - Reset overrides every other input, including mid-operation. An in-flight request is dropped and no result is produced.
- State machine:
  - IDLE: in_ready = 1. When in_valid is high at an edge, the request is accepted:
    - operand goes into acc;
    - shamt and op are latched;
    - stage index is set to 4;
    - state goes to SHIFT.
  - SHIFT: in_ready = 0. At each edge:
    - if shamt[idx] = 1, acc = acc shifted by 2^idx; otherwise acc is unchanged;
    - idx decrements by 1.
    - After the edge that processes idx = 0, state goes to DONE.
  - DONE: out_valid = 1 and data_result = acc, both held stable. When out_ready is high at an edge, state goes to IDLE and out_valid drops.
- Latency:
  - Accept edge is T. The stage edges are T+1 through T+5.
  - out_valid is high from T+5 onward.
  - The cycle count is fixed and does not depend on shamt; a stage with a zero bit still takes its cycle.
- Shift rules:
  - SLL fills vacated bits with zeros.
  - SRA fills vacated bits with the latched operand bit 31. The sign is carried by acc[31] and preserved through every stage.
  - Pass-through opcodes leave acc unchanged and still follow the 5-cycle path.
- Input latching: inputs are sampled only on the accept edge. Changes on the inputs during SHIFT or DONE have no effect.
- Back-to-back: no overlap. in_ready stays low from the accept edge until the edge after the out_ready handshake. Minimum throughput is one request per 7 cycles.
- Unused handshakes: out_ready is ignored outside DONE, and in_valid is ignored outside IDLE.
- data_result: holds its last value while in IDLE. It is valid only while out_valid is high.

Decomposition:
- Shared package `alu_pkg`, holding:
  - opcode constants ALU_OP_SLL = 5'b00100 and ALU_OP_SRA = 5'b00101;
  - state encoding IDLE / SHIFT / DONE.
- One combinational sub-module, `shift_stage`:
  - ports: 32-bit input, 5-bit stage index, arithmetic flag, enable; 32-bit output;
  - selects the shift by 16/8/4/2/1 from the index.
- The top level holds the FSM, the acc register, the idx counter and the handshake logic.

Test Plan:
- SRA 0x80000000 by 16 -> out_valid high exactly 5 cycles after accept; data_result = 0xFFFF8000.
- SRA 0x7FFF0000 by 16 -> 0x00007FFF. SLL 0x00000001 by 31 -> 0x80000000. SLL 0xDEADBEEF by 0 -> 0xDEADBEEF.
- SRA 0xF0000000 by 31 -> 0xFFFFFFFF. Opcode 00000 with shamt 7 -> 0x12345678 unchanged, with the same 5-cycle latency.
- Backpressure: hold out_ready = 0 for 3 cycles in DONE -> out_valid and data_result stay stable. A second in_valid during that time is not accepted (in_ready = 0). It is accepted on the edge after the out_ready handshake.
- Reset asserted at T+3 of an SRA by 5 -> the following cycle shows IDLE, in_ready = 1, out_valid = 0, busy = 0. No stale result ever appears.
- Inputs changed every cycle during SHIFT -> result reflects only the values latched at the accept edge.
